// File: rtl/xor_rot_pkg.sv
// Shared types and helpers for the xor/rotate sweep sequencer.
package xor_rot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sweep_state_t;

  // Select width for a rotator of width dw: enough bits to hold dw itself.
  function automatic int sel_w(input int dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/xor_rot_res_slice.sv
// Result register: loads when empty or when the held result is being taken,
// otherwise holds its contents stable until the downstream handshake.
module xor_rot_res_slice #(
  parameter int DW = 32,
  parameter int SW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [SW-1:0] sel_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          can_load_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [SW-1:0] sel_o,
  output logic          last_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [SW-1:0] sel_q;
  logic          last_q;

  assign can_load_o = !valid_q || ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      sel_q   <= sel_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;
  assign last_o  = last_q;

endmodule

// File: rtl/xor_rot_sweep_seq.sv
// Sequencer that sweeps a rotator's SELECT over a commanded range and streams
// each captured result out. Both ports use valid/ready: a transfer happens on
// a rising edge where valid and ready are both high; valid never waits on ready.
module xor_rot_sweep_seq
  import xor_rot_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_W      = sel_w(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0]      cmd_start,
  input  logic [SEL_W-1:0]      cmd_count,
  output logic [DATA_WIDTH-1:0] rot_a,
  output logic [DATA_WIDTH-1:0] rot_b,
  output logic [SEL_W-1:0]      rot_select,
  input  logic [DATA_WIDTH-1:0] rot_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [SEL_W-1:0]      res_select,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam int IW = SEL_W - 1;

  sweep_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]         sel_q;
  logic [SEL_W-1:0]      rem_q;
  logic                  zero_done_q;
  logic [SEL_W-1:0]      count_clamped;
  logic                  cmd_fire, cap_en, can_load, res_fire;

  assign count_clamped = (cmd_count > SEL_W'(DATA_WIDTH)) ? SEL_W'(DATA_WIDTH) : cmd_count;
  assign cmd_fire      = cmd_valid && cmd_ready;
  assign cap_en        = (state_q == RUN) && can_load;
  assign res_fire      = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_fire && (count_clamped != '0)) state_d = RUN;
      RUN:     if (cap_en && (rem_q == SEL_W'(1)))     state_d = DRAIN;
      DRAIN:   if (res_fire)                           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // done is gated by reset so a sweep discarded mid-flight never reports completion.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = !reset && (zero_done_q || ((state_q == DRAIN) && res_fire));
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      rem_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= cmd_fire && (count_clamped == '0);
      if (cmd_fire) begin
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        sel_q <= IW'(cmd_start);
        rem_q <= count_clamped;
      end else if (cap_en) begin
        sel_q <= sel_q + IW'(1);
        rem_q <= rem_q - SEL_W'(1);
      end
    end
  end

  assign rot_a      = a_q;
  assign rot_b      = b_q;
  assign rot_select = {1'b0, sel_q};

  xor_rot_res_slice #(
    .DW (DATA_WIDTH),
    .SW (SEL_W)
  ) u_res (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cap_en),
    .data_i     (rot_out),
    .sel_i      (rot_select),
    .last_i     (rem_q == SEL_W'(1)),
    .ready_i    (res_ready),
    .can_load_o (can_load),
    .valid_o    (res_valid),
    .data_o     (res_data),
    .sel_o      (res_select),
    .last_o     (res_last)
  );

endmodule
